mux8x1_dut: RTL and testbench

MUX8X1_DUT -- requirements
Module: mux8x1_dut

---
 rtl/mux8x1_dut_pkg.sv | 14 +
 rtl/mux8x1_dut_mux2x1.sv | 14 +
 rtl/mux8x1_dut.sv | 99 +++++++++
 tb/tb_mux8x1_dut.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux8x1_dut_pkg.sv
// Shared constants for the registered 8:1 mux tree.
// Also provides the helper that packs the three select pins into one index.
package mux8x1_dut_pkg;

    localparam int NUM_INPUTS = 8;
    localparam int NUM_LEAVES = 4;
    localparam int SEL_W      = 3;

    // s0 is the MSB and s2 is the LSB of the select index.
    function automatic logic [SEL_W-1:0] pack_sel(input logic s0, input logic s1, input logic s2);
        return {s0, s1, s2};
    endfunction

endpackage

// File: rtl/mux8x1_dut_mux2x1.sv
// Combinational 2:1 mux used as the leaf cell of the 8:1 tree.
// This cell holds no state.
module mux2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] o
);

    assign o = sel ? b : a;

endmodule

// File: rtl/mux8x1_dut.sv
// Three-level 2:1 mux tree with the intermediate levels exposed.
// Every level is registered at the outputs only, so all outputs share the same single-cycle latency.
module mux8x1_dut
    import mux8x1_dut_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y
);

    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] din  [NUM_INPUTS];
    logic [WIDTH-1:0] lvl1 [NUM_LEAVES];
    logic [WIDTH-1:0] lvl2_lo;
    logic [WIDTH-1:0] lvl2_hi;
    logic [WIDTH-1:0] lvl3;

    assign sel = pack_sel(s0, s1, s2);

    assign din[0] = i0;
    assign din[1] = i1;
    assign din[2] = i2;
    assign din[3] = i3;
    assign din[4] = i4;
    assign din[5] = i5;
    assign din[6] = i6;
    assign din[7] = i7;

    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_lvl1
        mux2x1 #(.WIDTH(WIDTH)) u_mux (
            .a   (din[2*g]),
            .b   (din[2*g+1]),
            .sel (sel[0]),
            .o   (lvl1[g])
        );
    end

    // Upper levels consume the combinational leaf results, not the output registers.
    mux2x1 #(.WIDTH(WIDTH)) u_lvl2_lo (
        .a   (lvl1[0]),
        .b   (lvl1[1]),
        .sel (sel[1]),
        .o   (lvl2_lo)
    );

    mux2x1 #(.WIDTH(WIDTH)) u_lvl2_hi (
        .a   (lvl1[2]),
        .b   (lvl1[3]),
        .sel (sel[1]),
        .o   (lvl2_hi)
    );

    mux2x1 #(.WIDTH(WIDTH)) u_lvl3 (
        .a   (lvl2_lo),
        .b   (lvl2_hi),
        .sel (sel[2]),
        .o   (lvl3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0 <= '0;
            y1 <= '0;
            y2 <= '0;
            y3 <= '0;
            y4 <= '0;
            y5 <= '0;
            y  <= '0;
        end else begin
            y0 <= lvl1[0];
            y1 <= lvl1[1];
            y2 <= lvl1[2];
            y3 <= lvl1[3];
            y4 <= lvl2_lo;
            y5 <= lvl2_hi;
            y  <= lvl3;
        end
    end

endmodule

// File: tb/tb_mux8x1_dut.sv
// Scoreboard bench for mux8x1_dut: stimulus pushes expected outputs, and a monitor checks them after each edge.
// Runs an 8-bit instance and a default-width instance that both share the same stimulus.
module tb_mux8x1_dut;

    typedef struct packed {
        logic [7:0] y0, y1, y2, y3, y4, y5, y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] i0, i1, i2, i3, i4, i5, i6, i7;
    logic s0, s1, s2;

    logic [7:0] y0_8, y1_8, y2_8, y3_8, y4_8, y5_8, y_8;
    logic       y0_1, y1_1, y2_1, y3_1, y4_1, y5_1, y_1;

    logic [7:0] din [8];
    exp_t       exp_q [$];
    exp_t       cur;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    mux8x1_dut #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7),
        .s0(s0), .s1(s1), .s2(s2),
        .y0(y0_8), .y1(y1_8), .y2(y2_8), .y3(y3_8), .y4(y4_8), .y5(y5_8), .y(y_8)
    );

    mux8x1_dut dut1 (
        .clk(clk), .rst_n(rst_n),
        .i0(i0[0]), .i1(i1[0]), .i2(i2[0]), .i3(i3[0]), .i4(i4[0]), .i5(i5[0]), .i6(i6[0]), .i7(i7[0]),
        .s0(s0), .s1(s1), .s2(s2),
        .y0(y0_1), .y1(y1_1), .y2(y2_1), .y3(y3_1), .y4(y4_1), .y5(y5_1), .y(y_1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_inputs(input int sel);
        i0 = din[0]; i1 = din[1]; i2 = din[2]; i3 = din[3];
        i4 = din[4]; i5 = din[5]; i6 = din[6]; i7 = din[7];
        {s0, s1, s2} = 3'(sel);
    endtask

    // Reference: a leaf picks within its pair, a mid-level output picks within its group of four, and y picks din[sel].
    task automatic apply(input int sel);
        exp_t e;
        set_inputs(sel);
        e.y0 = din[0 + sel % 2];
        e.y1 = din[2 + sel % 2];
        e.y2 = din[4 + sel % 2];
        e.y3 = din[6 + sel % 2];
        e.y4 = din[0 + sel % 4];
        e.y5 = din[4 + sel % 4];
        e.y  = din[sel];
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_y0"}, y0_8, 8'h00);
        chk({tag, "_y1"}, y1_8, 8'h00);
        chk({tag, "_y2"}, y2_8, 8'h00);
        chk({tag, "_y3"}, y3_8, 8'h00);
        chk({tag, "_y4"}, y4_8, 8'h00);
        chk({tag, "_y5"}, y5_8, 8'h00);
        chk({tag, "_y"},  y_8,  8'h00);
        chk({tag, "_w1_y"}, {7'b0, y_1}, 8'h00);
    endtask

    always @(posedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            #1;
            chk("y0", y0_8, cur.y0);
            chk("y1", y1_8, cur.y1);
            chk("y2", y2_8, cur.y2);
            chk("y3", y3_8, cur.y3);
            chk("y4", y4_8, cur.y4);
            chk("y5", y5_8, cur.y5);
            chk("y",  y_8,  cur.y);
            chk("w1_y0", {7'b0, y0_1}, {7'b0, cur.y0[0]});
            chk("w1_y4", {7'b0, y4_1}, {7'b0, cur.y4[0]});
            chk("w1_y5", {7'b0, y5_1}, {7'b0, cur.y5[0]});
            chk("w1_y",  {7'b0, y_1},  {7'b0, cur.y[0]});
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) din[k] = 8'hFF;
        set_inputs(5);
        #2;
        chk_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            for (int sel = 0; sel < 8; sel++) begin
                for (int j = 0; j < 8; j++) din[j] = 8'h00;
                din[k] = 8'h01;
                @(negedge clk);
                apply(sel);
            end
        end

        din[0] = 8'h00; din[1] = 8'h01; din[2] = 8'h00; din[3] = 8'h01;
        din[4] = 8'h01; din[5] = 8'h00; din[6] = 8'h01; din[7] = 8'h00;
        @(negedge clk);
        apply(5);

        for (int j = 0; j < 8; j++) din[j] = 8'h00;
        din[7] = 8'h01;
        @(negedge clk);
        apply(0);
        @(negedge clk);
        apply(7);
        #2;
        chk("latency_hold_y", y_8, 8'h00);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_y", y_8, 8'h00);
        chk("midrun_reset_w1_y", {7'b0, y_1}, 8'h00);
        #1;
        rst_n = 1'b1;
        apply(7);

        for (int k = 0; k < 8; k++) din[k] = 8'(8'h11 * k);
        for (int sel = 0; sel < 8; sel++) begin
            @(negedge clk);
            apply(sel);
        end

        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 8; k++) din[k] = 8'($urandom);
            @(negedge clk);
            apply(int'($urandom_range(0, 7)));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
